// File: rtl/byte_packet_buffer_if.sv
// Byte-stream and packet-output signals between the demodulator, the packet
// buffer and the packet consumer.
interface byte_packet_buffer_if;
  logic       pushByte;
  logic [7:0] Byte;
  logic       Sync;
  logic       lastByte;
  logic       stopOut;
  logic       outValid;
  logic [7:0] outByte;
  logic       outLast;
  logic       outReady;
  logic [7:0] pktCount;
  logic [7:0] errCount;

  modport master (
    output pushByte, Byte, Sync, lastByte, outReady,
    input  stopOut, outValid, outByte, outLast, pktCount, errCount
  );

  modport slave (
    input  pushByte, Byte, Sync, lastByte, outReady,
    output stopOut, outValid, outByte, outLast, pktCount, errCount
  );
endinterface

// File: rtl/byte_packet_buffer.sv
// Frames the demodulated byte stream into packets; only complete packets become
// visible to the consumer, partial or malformed ones are rolled back.
module byte_packet_buffer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int MAX_LEN     = 12,
  parameter int STOP_THRESH = 4
) (
  input  logic                clk,
  input  logic                reset,
  byte_packet_buffer_if.slave bus
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_LEN_P = PW'(MAX_LEN);
  localparam logic [PW-1:0] STOP_P    = PW'(STOP_THRESH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IN_PKT = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] len_q, len_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    pkt_cnt_q, err_cnt_q;
  logic          pkt_inc, err_inc;

  logic [8:0]        mem [DEPTH];
  logic [8:0]        rd_data_q;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] rd_addr;
  logic [8:0]        wdata;

  logic [PW-1:0] used, free_cnt;
  logic          full, no_room, out_valid;
  logic          is_start, is_pay, is_last;

  assign is_start  = bus.pushByte &  bus.Sync & ~bus.lastByte;
  assign is_pay    = bus.pushByte & ~bus.Sync & ~bus.lastByte;
  assign is_last   = bus.pushByte & ~bus.Sync &  bus.lastByte;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign full      = (used == DEPTH_P);
  // A new packet needs at least one slot beyond the committed data.
  assign no_room   = ((commit_ptr_q - rd_ptr_q) == DEPTH_P);
  assign free_cnt  = DEPTH_P - used;
  assign out_valid = (rd_ptr_q != commit_ptr_q);
  assign wdata     = {bus.lastByte, bus.Byte};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    state_d      = state_q;
    we           = 1'b0;
    waddr        = wr_ptr_q[ADDR_W-1:0];
    pkt_inc      = 1'b0;
    err_inc      = 1'b0;

    case (state_q)
      IN_PKT: begin
        if (is_start) begin
          err_inc = 1'b1;
          if (no_room) begin
            wr_ptr_d = commit_ptr_q;
            state_d  = DROP;
          end else begin
            we       = 1'b1;
            waddr    = commit_ptr_q[ADDR_W-1:0];
            wr_ptr_d = commit_ptr_q + 1'b1;
            len_d    = PW'(1);
          end
        end else if (is_pay || is_last) begin
          if (full || len_q == MAX_LEN_P) begin
            wr_ptr_d = commit_ptr_q;
            err_inc  = 1'b1;
            state_d  = DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            len_d    = len_q + 1'b1;
            if (is_last) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              pkt_inc      = 1'b1;
              state_d      = IDLE;
            end
          end
        end
      end
      default: begin
        // IDLE and DROP: wr_ptr_q equals commit_ptr_q here.
        if (is_start) begin
          if (no_room) begin
            err_inc = 1'b1;
            state_d = DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            len_d    = PW'(1);
            state_d  = IN_PKT;
          end
        end else if ((is_pay || is_last) && state_q == IDLE) begin
          err_inc = 1'b1;
        end
      end
    endcase

    if (out_valid && bus.outReady) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      state_q      <= IDLE;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      state_q      <= state_d;
      if (pkt_inc && pkt_cnt_q != 8'hFF) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (err_inc && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  // Registered head read with write-through, so a byte written this edge at
  // the next read address is seen by the head register straight away.
  assign rd_addr = reset ? '0 : rd_ptr_d[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= (we && waddr == rd_addr) ? wdata : mem[rd_addr];
  end

  assign bus.outValid = out_valid;
  assign bus.outByte  = out_valid ? rd_data_q[7:0] : 8'h00;
  assign bus.outLast  = out_valid & rd_data_q[8];
  assign bus.stopOut  = (free_cnt <= STOP_P);
  assign bus.pktCount = pkt_cnt_q;
  assign bus.errCount = err_cnt_q;
endmodule

// File: tb/tb_byte_packet_buffer.sv
// Bench for byte_packet_buffer: a vector table, directed corner sequences and
// random traffic against a queue-based packet model.
module tb_byte_packet_buffer;
  localparam int DEPTH       = 16;
  localparam int MAX_LEN     = 12;
  localparam int STOP_THRESH = 4;
  localparam int S_IDLE = 0, S_IN = 1, S_DROP = 2;

  logic clk = 1'b0;
  logic reset;

  byte_packet_buffer_if bus ();

  byte_packet_buffer #(
    .DEPTH(DEPTH), .ADDR_W(4), .MAX_LEN(MAX_LEN), .STOP_THRESH(STOP_THRESH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: committed bytes, the packet being received, and counters.
  logic [8:0] m_fifo[$];
  logic [8:0] m_pend[$];
  int m_state, m_pkt, m_err;

  typedef struct {
    bit push, sync, last;
    logic [7:0] b;
    bit ready;
    bit e_valid;
    logic [7:0] e_byte;
    bit e_last;
    int e_pkt, e_err;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pend.delete();
    m_state = S_IDLE;
    m_pkt = 0;
    m_err = 0;
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_edge(input bit push, input bit sync, input bit last,
                            input logic [7:0] b, input bit ready);
    int  used;
    bit  full, pop;
    used = m_fifo.size() + m_pend.size();
    full = (used == DEPTH);
    pop  = (m_fifo.size() > 0) && ready;
    if (push && !(sync && last)) begin
      if (sync) begin
        if (m_state == S_IN) begin
          bump_err();
          m_pend.delete();
        end
        if (m_fifo.size() == DEPTH) begin
          if (m_state != S_IN) bump_err();
          m_state = S_DROP;
        end else begin
          m_pend.delete();
          m_pend.push_back({1'b0, b});
          m_state = S_IN;
        end
      end else if (m_state == S_IDLE) begin
        bump_err();
      end else if (m_state == S_IN) begin
        if (full || m_pend.size() == MAX_LEN) begin
          m_pend.delete();
          bump_err();
          m_state = S_DROP;
        end else begin
          m_pend.push_back({last, b});
          if (last) begin
            foreach (m_pend[i]) m_fifo.push_back(m_pend[i]);
            m_pend.delete();
            if (m_pkt < 255) m_pkt++;
            m_state = S_IDLE;
          end
        end
      end
    end
    if (pop) begin
      $display("pop byte=0x%02h last=%0d", m_fifo[0][7:0], m_fifo[0][8]);
      void'(m_fifo.pop_front());
    end
  endtask

  task automatic check_model(input string tag);
    int  used;
    bit  ev;
    used = m_fifo.size() + m_pend.size();
    ev = (m_fifo.size() > 0);
    chk({tag, ".valid"}, int'(bus.outValid), int'(ev));
    chk({tag, ".byte"},  int'(bus.outByte),  ev ? int'(m_fifo[0][7:0]) : 0);
    chk({tag, ".last"},  int'(bus.outLast),  ev ? int'(m_fifo[0][8]) : 0);
    chk({tag, ".stop"},  int'(bus.stopOut),  int'((DEPTH - used) <= STOP_THRESH));
    chk({tag, ".pkt"},   int'(bus.pktCount), m_pkt);
    chk({tag, ".err"},   int'(bus.errCount), m_err);
  endtask

  task automatic drive(input bit push, input bit sync, input bit last,
                       input logic [7:0] b, input bit ready);
    bus.pushByte = push;
    bus.Sync     = sync;
    bus.lastByte = last;
    bus.Byte     = b;
    bus.outReady = ready;
  endtask

  task automatic step(input string tag, input bit push, input bit sync,
                      input bit last, input logic [7:0] b, input bit ready);
    drive(push, sync, last, b, ready);
    @(posedge clk);
    model_edge(push, sync, last, b, ready);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 8'h00, 0);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_model("reset");
  endtask

  initial begin
    int cnt;
    int rdy_pct[4]  = '{90, 20, 60, 100};
    int last_pct[4] = '{20, 25, 4, 15};

    // push sync last byte ready | valid byte last pkt err
    tbl[0]  = '{1, 1, 0, 8'hA1, 1, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 8'h22, 1, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 8'h33, 1, 1, 8'hA1, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 8'h00, 1, 1, 8'h22, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 8'h00, 1, 1, 8'h33, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0};
    tbl[6]  = '{1, 1, 1, 8'h55, 1, 0, 8'h00, 0, 1, 0};
    tbl[7]  = '{1, 1, 0, 8'h10, 1, 0, 8'h00, 0, 1, 0};
    tbl[8]  = '{1, 1, 1, 8'h55, 1, 0, 8'h00, 0, 1, 0};
    tbl[9]  = '{1, 0, 1, 8'h11, 1, 1, 8'h10, 0, 2, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 1, 1, 8'h11, 1, 2, 0};
    tbl[11] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2, 0};
    tbl[12] = '{1, 1, 0, 8'hA1, 1, 0, 8'h00, 0, 2, 0};
    tbl[13] = '{1, 0, 0, 8'h22, 1, 0, 8'h00, 0, 2, 0};
    tbl[14] = '{1, 1, 0, 8'hB1, 1, 0, 8'h00, 0, 2, 1};
    tbl[15] = '{1, 0, 1, 8'h44, 1, 1, 8'hB1, 0, 3, 1};
    tbl[16] = '{0, 0, 0, 8'h00, 1, 1, 8'h44, 1, 3, 1};
    tbl[17] = '{1, 0, 0, 8'h77, 1, 0, 8'h00, 0, 3, 2};

    drive(0, 0, 0, 8'h00, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].push, tbl[i].sync, tbl[i].last, tbl[i].b, tbl[i].ready);
      @(posedge clk);
      model_edge(tbl[i].push, tbl[i].sync, tbl[i].last, tbl[i].b, tbl[i].ready);
      @(negedge clk);
      $display("vec %0d push=%0d sync=%0d last=%0d byte=0x%02h -> valid=%0d out=0x%02h",
               i, tbl[i].push, tbl[i].sync, tbl[i].last, tbl[i].b,
               bus.outValid, bus.outByte);
      chk($sformatf("vec%0d.valid", i), int'(bus.outValid), int'(tbl[i].e_valid));
      chk($sformatf("vec%0d.byte", i),  int'(bus.outByte),  int'(tbl[i].e_byte));
      chk($sformatf("vec%0d.last", i),  int'(bus.outLast),  int'(tbl[i].e_last));
      chk($sformatf("vec%0d.stop", i),  int'(bus.stopOut),  0);
      chk($sformatf("vec%0d.pkt", i),   int'(bus.pktCount), tbl[i].e_pkt);
      chk($sformatf("vec%0d.err", i),   int'(bus.errCount), tbl[i].e_err);
    end

    // Fill to 12 committed, overflow the second packet, then drain.
    do_reset();
    step("fill", 1, 1, 0, 8'h00, 0);
    for (int i = 1; i <= 10; i++) step("fill", 1, 0, 0, 8'(i), 0);
    step("fill", 1, 0, 1, 8'h0B, 0);
    chk("fill12.stop", int'(bus.stopOut), 1);
    chk("fill12.valid", int'(bus.outValid), 1);
    step("ovf", 1, 1, 0, 8'hC0, 0);
    for (int i = 1; i <= 3; i++) step("ovf", 1, 0, 0, 8'hC0 + 8'(i), 0);
    step("ovf", 1, 0, 0, 8'hC4, 0);
    chk("ovf.err", int'(bus.errCount), 1);
    step("drop", 1, 0, 0, 8'hD0, 0);
    step("drop", 1, 0, 1, 8'hD1, 0);
    chk("drop.err", int'(bus.errCount), 1);
    chk("drop.stop", int'(bus.stopOut), 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.outValid) begin
        chk($sformatf("drain%0d.byte", cnt), int'(bus.outByte), cnt);
        cnt++;
      end
      step("drain", 0, 0, 0, 8'h00, 1);
    end
    chk("drain.count", cnt, 12);

    // Over-length packet: the 13th byte aborts it.
    do_reset();
    step("long", 1, 1, 0, 8'hE0, 1);
    for (int i = 1; i <= 11; i++) step("long", 1, 0, 0, 8'hE0 + 8'(i), 1);
    step("long", 1, 0, 1, 8'hEC, 1);
    repeat (3) step("long", 0, 0, 0, 8'h00, 1);
    chk("long.err", int'(bus.errCount), 1);
    chk("long.pkt", int'(bus.pktCount), 0);
    chk("long.valid", int'(bus.outValid), 0);

    // Reset with one committed packet and one partial packet in flight.
    do_reset();
    step("pre", 1, 1, 0, 8'h31, 0);
    step("pre", 1, 0, 0, 8'h32, 0);
    step("pre", 1, 0, 1, 8'h33, 0);
    step("pre", 1, 1, 0, 8'h41, 0);
    step("pre", 1, 0, 0, 8'h42, 0);
    do_reset();
    chk("midrst.valid", int'(bus.outValid), 0);
    chk("midrst.stop", int'(bus.stopOut), 0);
    chk("midrst.pkt", int'(bus.pktCount), 0);
    chk("midrst.err", int'(bus.errCount), 0);
    step("post", 1, 1, 0, 8'h51, 1);
    step("post", 1, 0, 0, 8'h52, 1);
    step("post", 1, 0, 1, 8'h53, 1);
    chk("post.head", int'(bus.outByte), 8'h51);
    repeat (3) step("post", 0, 0, 0, 8'h00, 1);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) step("sat", 1, 0, 0, 8'h77, 1);
    chk("sat.err", int'(bus.errCount), 255);

    // Random traffic across several readiness / packet-length regimes.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 800; c++) begin
        int  r;
        bit  p, s, l, rdy;
        r   = $urandom_range(0, 99);
        p   = ($urandom_range(0, 99) < 75);
        s   = 1'b0;
        l   = 1'b0;
        if (r < 12) s = 1'b1;
        else if (r < 17) begin s = 1'b1; l = 1'b1; end
        else if (r < 17 + last_pct[ph]) l = 1'b1;
        rdy = ($urandom_range(0, 99) < rdy_pct[ph]);
        if ($urandom_range(0, 999) == 0) do_reset();
        else step($sformatf("rnd%0d", ph), p, s, l, 8'($urandom), rdy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
